// File: rtl/apb_spi_slave_fifo.sv
// APB-programmable SPI mode-0 slave with parametrised TX/RX FIFOs, sticky
// error flags and a level interrupt. All SPI pins are oversampled in PCLK.

module apb_spi_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               wdata_i,
   output logic [W-1:0]               rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       empty_o,
   output logic                       full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == FULL_CNT);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   always_comb begin
      cnt_d = cnt_q;
      if (push_ok && !pop_ok)
         cnt_d = cnt_q + (AW+1)'(1);
      else if (!push_ok && pop_ok)
         cnt_d = cnt_q - (AW+1)'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

   // NOTE: storage is not reset; validity is tracked by the pointers and count alone.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end
endmodule

module apb_spi_slave_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [7:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        IRQ
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int BW = $clog2(DATA_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_e;

   state_e            state_q, state_d;
   logic [1:0]        ss_sync_q, sclk_sync_q, mosi_sync_q;
   logic              ss_prev_q, sclk_prev_q;
   logic              ss_s, sclk_s, mosi_s, ss_fall, sclk_rise, sclk_fall;
   logic [BW-1:0]     bit_cnt_q;
   logic [DATA_W-1:0] tx_sh_q, rx_sh_q;
   logic              rx_push_q, udr_pend_q;
   logic              en_q;
   logic [3:0]        irq_en_q;
   logic [2:0]        flags_q, flags_d, flags_set, flags_clr;
   logic              load, sample, word_done, tx_shift, frame_err_set;

   logic [DATA_W-1:0] tx_rdata, rx_rdata;
   logic [CW-1:0]     tx_count, rx_count;
   logic              tx_empty, tx_full, rx_empty, rx_full, tx_pop, tx_push, rx_pop;

   logic              access, a_ctrl, a_status, a_rxd, a_txd, a_irqen, mapped;
   logic              apb_err, wr_ok, rd_ok;
   logic [31:0]       status;
   logic              unused_pwdata;

   assign unused_pwdata = ^PWDATA;

   // ---------------- pin synchronisers and edge detection ----------------
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         ss_sync_q   <= 2'b11;
         sclk_sync_q <= 2'b00;
         mosi_sync_q <= 2'b00;
         ss_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make each stage take the previous stage's old value.
         ss_sync_q   <= {ss_sync_q[0], SS_n};
         sclk_sync_q <= {sclk_sync_q[0], SCLK};
         mosi_sync_q <= {mosi_sync_q[0], MOSI};
         ss_prev_q   <= ss_sync_q[1];
         sclk_prev_q <= sclk_sync_q[1];
      end
   end

   assign ss_s      = ss_sync_q[1];
   assign sclk_s    = sclk_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];
   assign ss_fall   = ss_prev_q & ~ss_s;
   assign sclk_rise = ~sclk_prev_q & sclk_s;
   assign sclk_fall = sclk_prev_q & ~sclk_s;

   // ---------------- engine FSM ----------------
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (ss_fall) state_d = S_LOAD;
         S_LOAD:  state_d = S_SHIFT;
         S_SHIFT: begin
            if (sclk_rise && (bit_cnt_q == LAST_BIT))
               state_d = ss_s ? S_IDLE : S_LOAD;
            else if (ss_s)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (!en_q) state_d = S_IDLE;
   end

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      load          = 1'b0;
      sample        = 1'b0;
      word_done     = 1'b0;
      tx_shift      = 1'b0;
      frame_err_set = 1'b0;
      if (en_q) begin
         case (state_q)
            S_LOAD:  load = 1'b1;
            S_SHIFT: begin
               sample        = sclk_rise;
               word_done     = sclk_rise && (bit_cnt_q == LAST_BIT);
               tx_shift      = sclk_fall && (bit_cnt_q != '0);
               frame_err_set = ss_s && !word_done && ((bit_cnt_q != '0) || sclk_rise);
            end
            default: ;
         endcase
      end
   end

   assign tx_pop = load & ~tx_empty;

   // Underflow is flagged only once an empty-loaded word actually starts shifting, so the
   // speculative reload after a frame's last bit does not raise it when SS_n then rises.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         bit_cnt_q  <= '0;
         rx_push_q  <= 1'b0;
         udr_pend_q <= 1'b0;
      end else begin
         if (load)
            tx_sh_q <= tx_empty ? '0 : tx_rdata;
         else if (tx_shift)
            tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};

         if (load)
            bit_cnt_q <= '0;
         else if (sample)
            bit_cnt_q <= word_done ? '0 : bit_cnt_q + BW'(1);

         if (sample) rx_sh_q <= {rx_sh_q[DATA_W-2:0], mosi_s};
         rx_push_q <= word_done;

         if (load)        udr_pend_q <= tx_empty;
         else if (sample) udr_pend_q <= 1'b0;
      end
   end

   assign MISO = en_q & ~ss_s & tx_sh_q[DATA_W-1];

   // ---------------- FIFOs ----------------
   apb_spi_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_i   (PCLK),
      .rst_i   (PRESET),
      .push_i  (tx_push),
      .pop_i   (tx_pop),
      .wdata_i (PWDATA[DATA_W-1:0]),
      .rdata_o (tx_rdata),
      .count_o (tx_count),
      .empty_o (tx_empty),
      .full_o  (tx_full)
   );

   apb_spi_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_i   (PCLK),
      .rst_i   (PRESET),
      .push_i  (rx_push_q),
      .pop_i   (rx_pop),
      .wdata_i (rx_sh_q),
      .rdata_o (rx_rdata),
      .count_o (rx_count),
      .empty_o (rx_empty),
      .full_o  (rx_full)
   );

   // ---------------- APB slave ----------------
   assign access   = PSEL & PENABLE;
   assign a_ctrl   = (PADDR == 8'h00);
   assign a_status = (PADDR == 8'h04);
   assign a_rxd    = (PADDR == 8'h08);
   assign a_txd    = (PADDR == 8'h0C);
   assign a_irqen  = (PADDR == 8'h10);
   assign mapped   = a_ctrl | a_status | a_rxd | a_txd | a_irqen;

   always_comb begin
      apb_err = 1'b0;
      if (access) begin
         if (!mapped)                                   apb_err = 1'b1;
         else if (PWRITE && a_rxd)                      apb_err = 1'b1;
         else if (!PWRITE && a_txd)                     apb_err = 1'b1;
         else if (!PWRITE && a_rxd && rx_empty)         apb_err = 1'b1;
         else if (PWRITE && a_txd && tx_full && !tx_pop) apb_err = 1'b1;
      end
   end

   assign wr_ok   = access & PWRITE & ~apb_err;
   assign rd_ok   = access & ~PWRITE & ~apb_err;
   assign rx_pop  = rd_ok & a_rxd;
   assign tx_push = wr_ok & a_txd;
   assign PSLVERR = apb_err;
   assign PREADY  = 1'b1;

   always_comb begin
      status        = '0;
      status[0]     = rx_empty;
      status[1]     = rx_full;
      status[2]     = tx_empty;
      status[3]     = tx_full;
      status[4]     = (state_q != S_IDLE);
      status[7:5]   = flags_q;
      status[12:8]  = 5'(rx_count);
      status[20:16] = 5'(tx_count);
   end

   always_comb begin
      PRDATA = '0;
      if (rd_ok) begin
         if (a_ctrl)        PRDATA = {31'b0, en_q};
         else if (a_status) PRDATA = status;
         else if (a_rxd)    PRDATA = 32'(rx_rdata);
         else if (a_irqen)  PRDATA = {28'b0, irq_en_q};
      end
   end

   // Flag order {FRAME_ERR, TX_UDR, RX_OVR}; a set event beats a coincident W1C.
   assign flags_set = {frame_err_set, udr_pend_q & sample, rx_push_q & rx_full & ~rx_pop};
   assign flags_clr = (wr_ok && a_status) ? PWDATA[7:5] : 3'b000;
   assign flags_d   = (flags_q & ~flags_clr) | flags_set;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         en_q     <= 1'b0;
         irq_en_q <= '0;
         flags_q  <= '0;
      end else begin
         if (wr_ok && a_ctrl)  en_q     <= PWDATA[0];
         if (wr_ok && a_irqen) irq_en_q <= PWDATA[3:0];
         flags_q <= flags_d;
      end
   end

   assign IRQ = (irq_en_q[0] & ~rx_empty) | (|(irq_en_q[3:1] & flags_q));
endmodule

// File: tb/tb_apb_spi_slave_fifo.sv
// Directed bench for apb_spi_slave_fifo: APB register access, SPI frames,
// FIFO overflow/underflow, frame errors, IRQ and asynchronous reset.

module tb_apb_spi_slave_fifo;
   logic        PCLK = 1'b0, PRESET = 1'b1;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [7:0]  PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;
   logic        SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
   logic        MISO, IRQ;

   int tests_run = 0;
   int tests_failed = 0;

   apb_spi_slave_fifo #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .IRQ(IRQ)
   );

   always #5 PCLK = ~PCLK;

   task automatic cyc(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      cyc(1);
      PENABLE = 1'b1;
      #2 err = PSLVERR;
      cyc(1);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      cyc(1);
      PENABLE = 1'b1;
      #2 begin d = PRDATA; err = PSLVERR; end
      cyc(1);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   // Master side: MOSI set after SCLK fall, MISO sampled just before SCLK rise.
   task automatic spi_bits(input logic [7:0] mosi_w, input int n, output logic [7:0] miso_w);
      miso_w = '0;
      for (int i = 0; i < n; i++) begin
         MOSI = mosi_w[7-i];
         cyc(6);
         miso_w[7-i] = MISO;
         SCLK = 1'b1;
         cyc(6);
         SCLK = 1'b0;
      end
      cyc(6);
   endtask

   task automatic spi_frame(input logic [7:0] mosi_w, output logic [7:0] miso_w);
      SS_n = 1'b0;
      cyc(8);
      spi_bits(mosi_w, 8, miso_w);
      SS_n = 1'b1;
      cyc(8);
   endtask

   task automatic test_reset;
      logic [31:0] d; logic e;
      cyc(3);
      tests_run++; if (PREADY !== 1'b1) begin tests_failed++; $display("FAIL reset_pready: got %b want 1", PREADY); end
      tests_run++; if (PSLVERR !== 1'b0) begin tests_failed++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
      tests_run++; if (MISO !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b want 0", MISO); end
      tests_run++; if (IRQ !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", IRQ); end
      tests_run++; if (PRDATA !== 32'h0) begin tests_failed++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
      PRESET = 1'b0;
      cyc(2);
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h5 || e !== 1'b0) begin tests_failed++; $display("FAIL reset_status: got %h err %b want 00000005 err 0", d, e); end
      apb_read(8'h00, d, e);
      tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h want 0", d); end
      apb_read(8'h10, d, e);
      tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_irqen: got %h want 0", d); end
   endtask

   task automatic test_basic_frame;
      logic [31:0] d; logic e; logic [7:0] m;
      apb_write(8'h00, 32'h1, e);
      apb_write(8'h0C, 32'hA5, e);
      tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL basic_txwr_err: got %b want 0", e); end
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0001_0001) begin tests_failed++; $display("FAIL basic_status_tx1: got %h want 00010001", d); end
      spi_frame(8'h3C, m);
      tests_run++; if (m !== 8'hA5) begin tests_failed++; $display("FAIL basic_miso: got %h want a5", m); end
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0000_0104) begin tests_failed++; $display("FAIL basic_status_rx1: got %h want 00000104", d); end
      apb_write(8'h10, 32'h1, e);
      tests_run++; if (IRQ !== 1'b1) begin tests_failed++; $display("FAIL basic_irq_rxne: got %b want 1", IRQ); end
      apb_read(8'h08, d, e);
      tests_run++; if (d !== 32'h3C || e !== 1'b0) begin tests_failed++; $display("FAIL basic_rxdata: got %h err %b want 3c err 0", d, e); end
      tests_run++; if (IRQ !== 1'b0) begin tests_failed++; $display("FAIL basic_irq_clear: got %b want 0", IRQ); end
      apb_write(8'h10, 32'h0, e);
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h5) begin tests_failed++; $display("FAIL basic_status_end: got %h want 00000005", d); end
   endtask

   task automatic test_overflow;
      logic [31:0] d; logic e; logic [7:0] m;
      logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 5; i++) spi_frame(words[i], m);
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0000_0466) begin tests_failed++; $display("FAIL ovr_status: got %h want 00000466", d); end
      for (int i = 0; i < 4; i++) begin
         apb_read(8'h08, d, e);
         tests_run++; if (d !== 32'(words[i]) || e !== 1'b0) begin tests_failed++; $display("FAIL ovr_read%0d: got %h err %b want %h err 0", i, d, e, words[i]); end
      end
      apb_read(8'h08, d, e);
      tests_run++; if (d !== 32'h0 || e !== 1'b1) begin tests_failed++; $display("FAIL ovr_empty_read: got %h err %b want 0 err 1", d, e); end
      apb_write(8'h04, 32'h20, e);
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0000_0045) begin tests_failed++; $display("FAIL ovr_w1c: got %h want 00000045", d); end
      apb_write(8'h04, 32'h40, e);
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h5) begin tests_failed++; $display("FAIL ovr_udr_w1c: got %h want 00000005", d); end
   endtask

   task automatic test_tx_underflow;
      logic [31:0] d; logic e; logic [7:0] m;
      apb_write(8'h10, 32'h4, e);
      tests_run++; if (IRQ !== 1'b0) begin tests_failed++; $display("FAIL udr_irq_before: got %b want 0", IRQ); end
      spi_frame(8'h5A, m);
      tests_run++; if (m !== 8'h00) begin tests_failed++; $display("FAIL udr_miso: got %h want 00", m); end
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0000_0144) begin tests_failed++; $display("FAIL udr_status: got %h want 00000144", d); end
      apb_read(8'h08, d, e);
      tests_run++; if (d !== 32'h5A) begin tests_failed++; $display("FAIL udr_rxdata: got %h want 5a", d); end
      tests_run++; if (IRQ !== 1'b1) begin tests_failed++; $display("FAIL udr_irq_set: got %b want 1", IRQ); end
      apb_write(8'h04, 32'h40, e);
      tests_run++; if (IRQ !== 1'b0) begin tests_failed++; $display("FAIL udr_irq_w1c: got %b want 0", IRQ); end
      apb_write(8'h10, 32'h0, e);
   endtask

   task automatic test_frame_error;
      logic [31:0] d; logic e; logic [7:0] m;
      apb_write(8'h0C, 32'h81, e);
      SS_n = 1'b0;
      cyc(8);
      spi_bits(8'hE0, 3, m);
      SS_n = 1'b1;
      cyc(8);
      tests_run++; if (m[7:5] !== 3'b100) begin tests_failed++; $display("FAIL ferr_miso: got %b want 100", m[7:5]); end
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0000_0085) begin tests_failed++; $display("FAIL ferr_status: got %h want 00000085", d); end
      apb_write(8'h04, 32'h80, e);
      apb_write(8'h0C, 32'h96, e);
      spi_frame(8'hC3, m);
      tests_run++; if (m !== 8'h96) begin tests_failed++; $display("FAIL ferr_next_miso: got %h want 96", m); end
      apb_read(8'h08, d, e);
      tests_run++; if (d !== 32'hC3) begin tests_failed++; $display("FAIL ferr_next_rx: got %h want c3", d); end
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h5) begin tests_failed++; $display("FAIL ferr_status_end: got %h want 00000005", d); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] d; logic e; logic [7:0] m1, m2;
      apb_write(8'h0C, 32'h12, e);
      apb_write(8'h0C, 32'h34, e);
      SS_n = 1'b0;
      cyc(8);
      spi_bits(8'hAB, 8, m1);
      spi_bits(8'hCD, 8, m2);
      SS_n = 1'b1;
      cyc(8);
      tests_run++; if (m1 !== 8'h12 || m2 !== 8'h34) begin tests_failed++; $display("FAIL b2b_miso: got %h %h want 12 34", m1, m2); end
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0000_0204) begin tests_failed++; $display("FAIL b2b_status: got %h want 00000204", d); end
      apb_read(8'h08, d, e);
      tests_run++; if (d !== 32'hAB) begin tests_failed++; $display("FAIL b2b_rx0: got %h want ab", d); end
      apb_read(8'h08, d, e);
      tests_run++; if (d !== 32'hCD) begin tests_failed++; $display("FAIL b2b_rx1: got %h want cd", d); end
   endtask

   task automatic test_en_abort;
      logic [31:0] d; logic e; logic [7:0] m;
      apb_write(8'h0C, 32'h01, e);
      apb_write(8'h0C, 32'h02, e);
      SS_n = 1'b0;
      cyc(8);
      spi_bits(8'hFF, 3, m);
      apb_write(8'h00, 32'h0, e);
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0001_0001) begin tests_failed++; $display("FAIL abort_status: got %h want 00010001", d); end
      SS_n = 1'b1;
      cyc(8);
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0001_0001) begin tests_failed++; $display("FAIL abort_no_ferr: got %h want 00010001", d); end
      apb_write(8'h00, 32'h1, e);
      spi_frame(8'h77, m);
      tests_run++; if (m !== 8'h02) begin tests_failed++; $display("FAIL abort_retained_tx: got %h want 02", m); end
      apb_read(8'h08, d, e);
      tests_run++; if (d !== 32'h77) begin tests_failed++; $display("FAIL abort_rx: got %h want 77", d); end
   endtask

   task automatic test_apb_errors;
      logic [31:0] d; logic e;
      apb_write(8'h14, 32'h1, e);
      tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL err_unmapped_wr: got %b want 1", e); end
      apb_read(8'h0C, d, e);
      tests_run++; if (e !== 1'b1 || d !== 32'h0) begin tests_failed++; $display("FAIL err_txdata_rd: got err %b data %h want 1 0", e, d); end
      apb_write(8'h08, 32'h1, e);
      tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL err_rxdata_wr: got %b want 1", e); end
      apb_read(8'h14, d, e);
      tests_run++; if (e !== 1'b1 || d !== 32'h0) begin tests_failed++; $display("FAIL err_unmapped_rd: got err %b data %h want 1 0", e, d); end
      apb_write(8'h0C, 32'hFF, e);
      apb_write(8'h0C, 32'h81, e);
      apb_write(8'h0C, 32'h22, e);
      apb_write(8'h0C, 32'h33, e);
      tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL err_tx_fill: got %b want 0", e); end
      apb_write(8'h0C, 32'h44, e);
      tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL err_tx_full_wr: got %b want 1", e); end
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0004_0009) begin tests_failed++; $display("FAIL err_status_txfull: got %h want 00040009", d); end
   endtask

   task automatic test_reset_midframe;
      logic [31:0] d; logic e; logic [7:0] m;
      apb_write(8'h10, 32'h1, e);
      SS_n = 1'b0;
      cyc(8);
      spi_bits(8'h66, 8, m);
      tests_run++; if (m !== 8'hFF) begin tests_failed++; $display("FAIL rst_word_miso: got %h want ff", m); end
      tests_run++; if (MISO !== 1'b1 || IRQ !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_state: got miso %b irq %b want 1 1", MISO, IRQ); end
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h0002_0110) begin tests_failed++; $display("FAIL rst_busy_status: got %h want 00020110", d); end
      #2 PRESET = 1'b1;
      #1;
      tests_run++; if (MISO !== 1'b0 || IRQ !== 1'b0) begin tests_failed++; $display("FAIL rst_async_pins: got miso %b irq %b want 0 0", MISO, IRQ); end
      tests_run++; if (PRDATA !== 32'h0 || PSLVERR !== 1'b0 || PREADY !== 1'b1) begin tests_failed++; $display("FAIL rst_async_apb: got prdata %h slverr %b ready %b", PRDATA, PSLVERR, PREADY); end
      cyc(2);
      PRESET = 1'b0;
      SS_n = 1'b1;
      cyc(8);
      apb_read(8'h04, d, e);
      tests_run++; if (d !== 32'h5) begin tests_failed++; $display("FAIL rst_status_after: got %h want 00000005", d); end
      apb_read(8'h00, d, e);
      tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL rst_ctrl_after: got %h want 0", d); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_overflow();
      test_tx_underflow();
      test_frame_error();
      test_back_to_back();
      test_en_abort();
      test_apb_errors();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/apb_spi_slave_fifo.md
# apb_spi_slave_fifo

Parametrised APB-programmable SPI slave with TX/RX FIFOs. It is the next generation of the APB/SPI wrapper: configurable word width and FIFO depth, an explicit SCLK input, sticky error flags and an interrupt output. It sits on the APB peripheral bus and faces an external SPI master. All SPI inputs are oversampled in the PCLK domain.

## Interface
- DATA_W, 8: SPI word width in bits (4..16).
- FIFO_DEPTH, 4: entries per FIFO (power of 2, 2..16).
- PCLK  in  1  system/APB clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  8  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1 (zero wait states).
- PSLVERR  out  1  error response, valid in access phase.
- SS_n, SCLK, MOSI  in  1 each  SPI from master, asynchronous to PCLK.
- MISO  out  1  SPI to master.
- IRQ  out  1  level interrupt.

## Operation
- Register map:
  - 0x00 CTRL (RW): [0] EN.
  - 0x04 STATUS: [0] RX_EMPTY, [1] RX_FULL, [2] TX_EMPTY, [3] TX_FULL, [4] BUSY, [5] RX_OVR, [6] TX_UDR, [7] FRAME_ERR. Bits [7:5] are sticky and write-1-to-clear. [12:8] RX count, [20:16] TX count.
  - 0x08 RXDATA (RO): reading pops the RX FIFO.
  - 0x0C TXDATA (WO): writing pushes PWDATA[DATA_W-1:0].
  - 0x10 IRQ_EN (RW): [0] RXNE, [1] RX_OVR, [2] TX_UDR, [3] FRAME_ERR.
- PSLVERR=1 in the access phase for any of these; the access then has no side effect:
  - unmapped address;
  - write to 0x08;
  - read of 0x0C;
  - read of RXDATA when RX is empty (PRDATA=0);
  - write of TXDATA when TX is full.
- Unused PRDATA bits read 0.
- IRQ = (IRQ_EN[0] & !RX_EMPTY) | |(IRQ_EN[3:1] & STATUS[7:5]).
- SPI mode 0, MSB first.
  - SS_n, SCLK and MOSI each pass through a 2-flop synchronizer; edges are detected on the synchronized signals.
  - MOSI is sampled on SCLK rise; MISO shifts on SCLK fall.
- Engine states:
  - IDLE: SS_n high, or EN=0.
  - LOAD: on SS_n falling edge with EN=1. Pop the TX head into the shift register. If TX is empty, load 0 and set TX_UDR.
  - SHIFT: count DATA_W rising edges. At the last rise, push the received word to RX. If RX is full, drop the word and set RX_OVR.
  - After the last rise: if SS_n is still low, return to LOAD for a back-to-back word. Otherwise go to IDLE.
  - SS_n rising in SHIFT with bit count in 1..DATA_W-1: discard the partial word, set FRAME_ERR, go to IDLE. A popped TX word is not restored.
- BUSY = state != IDLE.
- MISO = shift-register MSB while SS_n (synchronized) is low and EN=1; otherwise 0.
- EN cleared mid-frame: abort to IDLE, no flag set. FIFO contents are retained.
- Simultaneous events:
  - RX push and APB pop in the same cycle on a full FIFO: both succeed, count unchanged, no RX_OVR.
  - TX pop and APB push on a full TX FIFO: the push is accepted.
  - A W1C write that coincides with a flag-set event leaves the flag set.
- Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.

## Timing
- Reset values: PRDATA=0, PREADY=1, PSLVERR=0, MISO=0, IRQ=0, CTRL=0, IRQ_EN=0, sticky flags 0, both FIFOs empty, engine in IDLE.
- APB writes take effect at the PCLK rise ending the access phase.
- APB reads: PRDATA and PSLVERR are combinational during the access phase. The RX pop occurs at the rise ending the access phase.
- SPI pin to internal edge: 3 PCLK (2 sync + 1 detect). Minimum SCLK high and low times: 4 PCLK each.
- SS_n fall to first MISO bit valid: 4 PCLK.
- Last SCLK rise to RX count/STATUS update: 4 PCLK. IRQ follows 0 cycles later (combinational).
- A TXDATA write is visible in STATUS TX count on the next cycle.

## Test plan
- Reset, then read 0x04 -> 0x00000005 (RX and TX empty). PREADY=1, PSLVERR=0. MISO=0.
- EN=1, write TXDATA 0xA5, run an 8-bit frame with MOSI=0x3C -> MISO shifts out 10100101; RXDATA reads 0x3C; STATUS back to 0x5.
- Five frames with no reads (FIFO_DEPTH=4) -> RX_FULL=1, RX_OVR=1, RXDATA reads the first four words in order; a fifth read gives PSLVERR=1. Write 0x20 to 0x04 -> RX_OVR clears.
- Frame with TX empty -> MISO=0 for all bits, TX_UDR=1. With IRQ_EN=0x4, IRQ=1 until W1C.
- SS_n rises after 3 SCLK -> FRAME_ERR=1, RX count=0, BUSY=0. Next full frame is received correctly.
- Write 0x14 and read 0x0C -> PSLVERR=1. PRESET asserted mid-frame -> all outputs at reset values immediately (asynchronous).
